// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with registered result flags.
// Define LOGIC_POPCNT_EN to add the registered out_popcnt output.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_ones,
`ifdef LOGIC_POPCNT_EN
  output logic [$clog2(WIDTH+1)-1:0] out_popcnt,
`endif
  output logic             out_parity
);

  localparam int PCW = $clog2(WIDTH + 1);

  function automatic logic [WIDTH-1:0] f_logic_op(
    input logic [OPW-1:0]   op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] res;
    case (op)
      3'b000:  res = ~a;
      3'b001:  res = a & b;
      3'b010:  res = a | b;
      3'b011:  res = a ^ b;
      3'b100:  res = ~(a & b);
      3'b101:  res = ~(a | b);
      3'b110:  res = ~(a ^ b);
      3'b111:  res = a;
      default: res = {WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  function automatic logic f_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  function automatic logic [PCW-1:0] f_popcnt(input logic [WIDTH-1:0] v);
    logic [PCW-1:0] cnt;
    cnt = {PCW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + {{(PCW-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_zero;
  logic             r_out_ones;
  logic             r_out_parity;
  logic [PCW-1:0]   r_out_popcnt;

  logic             w_s2_ready;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_s1_fire;
  logic [WIDTH-1:0] w_op_result;

  // Ready chain and handshake decode; in_ready is the only combinational in/out path.
  always_comb begin
    w_s2_ready  = !r_out_valid || out_ready;
    w_in_ready  = !r_s1_valid || w_s2_ready;
    w_in_fire   = in_valid && w_in_ready;
    w_s1_fire   = r_s1_valid && w_s2_ready;
    w_op_result = f_logic_op(in_op, in_a, in_b);
  end

  // Stage 1: captures the op result on an input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= {WIDTH{1'b0}};
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= w_op_result;
    end else if (w_s1_fire) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register; data and flags only change on an s1 transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= {WIDTH{1'b0}};
      r_out_zero   <= 1'b0;
      r_out_ones   <= 1'b0;
      r_out_parity <= 1'b0;
      r_out_popcnt <= {PCW{1'b0}};
    end else if (w_s1_fire) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= r_s1_data;
      r_out_zero   <= ~|r_s1_data;
      r_out_ones   <= &r_s1_data;
      r_out_parity <= f_parity(r_s1_data);
`ifdef LOGIC_POPCNT_EN
      r_out_popcnt <= f_popcnt(r_s1_data);
`else
      r_out_popcnt <= {PCW{1'b0}};
`endif
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_zero   = r_out_zero;
  assign out_ones   = r_out_ones;
  assign out_parity = r_out_parity;
`ifdef LOGIC_POPCNT_EN
  assign out_popcnt = r_out_popcnt;
`else
  logic w_unused_popcnt;
  assign w_unused_popcnt = ^r_out_popcnt;
`endif

endmodule
